// File: rtl/mem_resp_pkg.sv
// Shared address map, STATUS bit layout and address decode
// for the MEM-stage data responder.
package mem_resp_pkg;

  localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
  localparam logic [31:0] RAM_LIMIT   = 32'h0000_00FF;
  localparam logic [31:0] TXDATA_ADDR = 32'h0000_0100;
  localparam logic [31:0] STATUS_ADDR = 32'h0000_0104;
  localparam logic [31:0] CYCLE_ADDR  = 32'h0000_0108;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_ERR     = 2;
  localparam int ST_CNT_LSB = 3;

  typedef enum logic [2:0] {
    T_RAM,
    T_TX,
    T_STAT,
    T_CYC,
    T_NONE
  } tgt_e;

  function automatic tgt_e decode(input logic [31:0] a);
    logic [31:0] w;
    tgt_e t;
    w = a & ~32'h3;
    unique case (1'b1)
      (w <= RAM_LIMIT):   t = T_RAM;
      (w == TXDATA_ADDR): t = T_TX;
      (w == STATUS_ADDR): t = T_STAT;
      (w == CYCLE_ADDR):  t = T_CYC;
      default:            t = T_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy counter.
// head reads as zero whenever the FIFO is empty.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [W-1:0]               head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: RAM, transmit FIFO, STATUS and CYCLE
// registers behind the MEM-stage load/store port.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int RAM_AW     = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        stall,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tgt_e          tgt;
  logic          push, pop, full, empty;
  logic [CW-1:0] cnt;
  logic [7:0]    head;
  logic [7:0]    st_b;
  logic [31:0]   ram_q [2**RAM_AW];
  logic [31:0]   cyc_q, cyc_d;
  logic          err_q, err_d;

  assign tgt      = decode(addr);
  assign stall    = we & (tgt == T_TX) & full;
  assign push     = we & (tgt == T_TX) & ~full;
  assign tx_valid = ~empty;
  assign tx_data  = head;
  assign pop      = tx_valid & tx_ready;

  sync_fifo #(
    .W     (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (push),
    .din   (wdata[7:0]),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .count (cnt),
    .head  (head)
  );

  always_comb begin
    st_b                  = '0;
    st_b[ST_EMPTY]        = empty;
    st_b[ST_FULL]         = full;
    st_b[ST_ERR]          = err_q;
    st_b[7:ST_CNT_LSB]    = 5'(cnt);
  end

  always_comb begin
    rdata = '0;
    unique case (tgt)
      T_RAM:   rdata = ram_q[addr[RAM_AW+1:2]];
      T_STAT:  rdata = {24'b0, st_b};
      T_CYC:   rdata = cyc_q;
      default: rdata = '0;
    endcase
  end

  // A CYCLE write lands already advanced by the edge it is taken on.
  always_comb begin
    cyc_d = cyc_q + 32'd1;
    if (we && tgt == T_CYC) cyc_d = wdata + 32'd1;
    err_d = err_q;
    if ((we || re) && tgt == T_NONE)
      err_d = 1'b1;
    else if (we && tgt == T_STAT && wdata[ST_ERR])
      err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (we && tgt == T_RAM) ram_q[addr[RAM_AW+1:2]] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q <= '0;
      err_q <= 1'b0;
    end else begin
      cyc_q <= cyc_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed plan then random
// traffic, checked against a queue/array reference model.
module tb_mem_responder;
  import mem_resp_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] addr, wdata, rdata;
  logic        we, re, stall, tx_valid, tx_ready;
  logic [7:0]  tx_data;

  always #5 clk = ~clk;

  mem_responder #(.RAM_AW(6), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .re       (re),
    .rdata    (rdata),
    .stall    (stall),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  typedef struct {
    bit          chk_rd;
    logic [31:0] rd;
    logic        st;
    logic        txv;
    bit          chk_txd;
    logic [7:0]  txd;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] m_ram [64];
  logic [7:0]  m_fifo[$];
  logic [31:0] m_cnt;
  bit          m_err;
  bit          last_stall;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check32(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit unmapped(logic [31:0] w);
    return w >= 32'h100 && w != 32'h100 && w != 32'h104 && w != 32'h108;
  endfunction

  function automatic logic [31:0] m_read(logic [31:0] a);
    logic [31:0] w;
    int n;
    w = a & 32'hFFFF_FFFC;
    n = m_fifo.size();
    if (w < 32'h100) return m_ram[w[7:2]];
    if (w == 32'h104)
      return 32'(n * 8 + (m_err ? 4 : 0) + (n == 4 ? 2 : 0) + (n == 0 ? 1 : 0));
    if (w == 32'h108) return m_cnt;
    return 32'h0;
  endfunction

  task automatic model_edge();
    logic [31:0] w;
    bit pop, psh;
    w   = addr & 32'hFFFF_FFFC;
    pop = m_fifo.size() > 0 && tx_ready;
    psh = we && w == 32'h100 && m_fifo.size() < 4;
    if (pop) void'(m_fifo.pop_front());
    if (psh) begin
      m_fifo.push_back(wdata[7:0]);
      tx_q.push_back(wdata[7:0]);
    end
    if (we && w < 32'h100) m_ram[w[7:2]] = wdata;
    if ((we || re) && unmapped(w)) m_err = 1'b1;
    else if (we && w == 32'h104 && wdata[2]) m_err = 1'b0;
    m_cnt = (we && w == 32'h108) ? wdata + 32'd1 : m_cnt + 32'd1;
  endtask

  task automatic step(logic [31:0] a, logic [31:0] d, bit w, bit r, bit rdy);
    exp_t e;
    addr = a; wdata = d; we = w; re = r; tx_ready = rdy;
    e.chk_rd  = r;
    e.rd      = m_read(a);
    e.st      = w && ((a & 32'hFFFF_FFFC) == 32'h100) && m_fifo.size() == 4;
    e.txv     = m_fifo.size() > 0;
    e.chk_txd = 0;
    e.txd     = 8'h0;
    last_stall = e.st;
    exp_q.push_back(e);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic reset_pulse();
    exp_t e;
    addr = 32'h104; wdata = 0; we = 0; re = 1; tx_ready = 0;
    #2 reset_n = 1'b0;
    m_fifo.delete();
    tx_q.delete();
    m_cnt = 0;
    m_err = 0;
    e.chk_rd = 1; e.rd = 32'h1; e.st = 0; e.txv = 0;
    e.chk_txd = 1; e.txd = 8'h0;
    exp_q.push_back(e);
    @(negedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 8; k++) step(32'h0, 32'h0, 0, 0, 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk_rd) check32("rdata", rdata, e.rd);
        check32("stall", {31'b0, stall}, {31'b0, e.st});
        check32("tx_valid", {31'b0, tx_valid}, {31'b0, e.txv});
        if (e.chk_txd) check32("tx_data_reset", {24'b0, tx_data}, {24'b0, e.txd});
      end
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL tx_pop: got %h expected no byte", tx_data);
        end else begin
          check32("tx_byte", {24'b0, tx_data}, {24'b0, tx_q.pop_front()});
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] a, d;
    bit w, r, rdy;
    exp_t e;
    reset_n = 1'b0;
    addr = 32'h104; wdata = 0; we = 0; re = 1; tx_ready = 0;
    m_cnt = 0; m_err = 0; last_stall = 0;
    e.chk_rd = 1; e.rd = 32'h1; e.st = 0; e.txv = 0;
    e.chk_txd = 1; e.txd = 8'h0;
    exp_q.push_back(e);
    @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < 10; i++) step(32'h0, 0, 0, 0, 0);
    step(32'h108, 0, 0, 1, 0);

    for (int i = 0; i < 64; i++) step(32'(i * 4), $urandom, 1, 0, 0);

    step(32'h04, 32'hDEADBEEF, 1, 0, 0);
    step(32'hFC, 32'h12345678, 1, 0, 0);
    step(32'h04, 0, 0, 1, 0);
    step(32'hFC, 0, 0, 1, 0);
    step(32'h08, 0, 0, 1, 0);
    step(32'h104, 0, 0, 1, 0);

    for (int i = 0; i < 4; i++) step(32'h100, 32'(8'h41 + i), 1, 0, 0);
    step(32'h104, 0, 0, 1, 0);
    step(32'h100, 32'h45, 1, 0, 0);
    step(32'h100, 32'h45, 1, 0, 1);
    step(32'h100, 32'h45, 1, 0, 0);
    step(32'h104, 0, 0, 1, 0);
    drain();

    step(32'h100, 32'h61, 1, 0, 0);
    step(32'h100, 32'h62, 1, 0, 0);
    step(32'h100, 32'h55, 1, 0, 1);
    step(32'h104, 0, 0, 1, 0);
    drain();

    step(32'h200, 0, 0, 1, 0);
    step(32'h104, 0, 0, 1, 0);
    step(32'h104, 32'h4, 1, 0, 0);
    step(32'h104, 0, 0, 1, 0);

    step(32'h108, 32'hFFFF_FFFE, 1, 0, 0);
    step(32'h0, 0, 0, 0, 0);
    step(32'h108, 0, 0, 1, 0);

    a = 0; d = 0; w = 0; r = 0;
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) begin
        d = $urandom;
        case ($urandom_range(0, 9))
          0, 1: begin a = $urandom_range(0, 255); w = 1; r = 0; end
          2, 3: begin a = $urandom_range(0, 255); w = 0; r = 1; end
          4, 5: begin a = 32'h100 | $urandom_range(0, 3); w = 1; r = 0; end
          6:    begin a = 32'h104; r = 1; w = ($urandom_range(0, 3) == 0); end
          7:    begin a = 32'h108; r = 1; w = ($urandom_range(0, 7) == 0); end
          8:    begin a = $urandom; r = $urandom_range(0, 1) == 1; w = $urandom_range(0, 1) == 1; end
          default: begin a = 32'h10C + 4 * $urandom_range(0, 60); w = 0; r = 1; end
        endcase
      end
      rdy = ($urandom_range(0, 3) == 0);
      step(a, d, w, r, rdy);
    end
    drain();

    for (int i = 0; i < 3; i++) step(32'h100, 32'(8'h70 + i), 1, 0, 0);
    reset_pulse();
    step(32'h108, 0, 0, 1, 0);
    step(32'h104, 0, 0, 1, 0);
    drain();

    @(negedge clk);
    #1;
    check32("tx_leftover", 32'(tx_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
